// File: rtl/stream_parity_unit.sv
// Streaming frame parity generator/checker with a valid/ready result port.
// Optional error counter enabled by defining PARITY_ERR_CNT_EN.
module stream_parity_unit #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter bit ODD       = 1'b0,
    localparam int CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_check,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             par_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CW-1:0]    out_words,
`ifdef PARITY_ERR_CNT_EN
    input  logic             err_clr,
    output logic [7:0]       err_cnt,
`endif
    output logic             out_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    state_t          state_q, state_d;
    logic            acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mode_q, mode_d;
    logic            par_q, par_d;
    logic [CW-1:0]   words_q, words_d;
    logic            err_q, err_d;

    logic            word_xfer;
    logic            res_xfer;
    logic            is_last;
    logic            word_par;
    logic            mode_eff;
    logic            frame_par;

    assign in_ready   = (state_q == ACCUM);
    assign out_valid  = (state_q == HOLD);
    assign out_parity = par_q;
    assign out_words  = words_q;
    assign out_err    = err_q;

    assign word_xfer = in_valid & in_ready;
    assign res_xfer  = out_valid & out_ready;
    assign word_par  = ^in_data;
    assign is_last   = in_last | (cnt_q == LAST_CNT);

    // the first word of a frame uses the live mode input, later words the latched one
    assign mode_eff  = (cnt_q == '0) ? mode_check : mode_q;
    assign frame_par = acc_q ^ word_par ^ ODD;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        par_d   = par_q;
        words_d = words_q;
        err_d   = err_q;
        unique case (state_q)
            ACCUM: begin
                if (word_xfer) begin
                    mode_d = mode_eff;
                    if (is_last) begin
                        par_d   = frame_par;
                        words_d = cnt_q + 1'b1;
                        err_d   = mode_eff & (frame_par != par_in);
                        acc_d   = acc_q ^ word_par;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_q ^ word_par;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (res_xfer) begin
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            par_q   <= 1'b0;
            words_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            par_q   <= par_d;
            words_q <= words_d;
            err_q   <= err_d;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    // clear has priority over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (err_clr) begin
            err_cnt <= 8'd0;
        end else if (res_xfer && err_q && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_parity_unit.sv
// Directed bench for stream_parity_unit: even and odd parity instances
// driven from one stimulus sequence.
module tb_stream_parity_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_check = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       par_in = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready0, out_valid0, out_parity0, out_err0;
    logic       in_ready1, out_valid1, out_parity1, out_err1;
    logic [2:0] out_words0, out_words1;
`ifdef PARITY_ERR_CNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt0, err_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_parity_unit #(.WIDTH(8), .FRAME_LEN(4), .ODD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode_check(mode_check),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_last(in_last), .par_in(par_in), .out_valid(out_valid0),
        .out_ready(out_ready), .out_parity(out_parity0),
        .out_words(out_words0),
`ifdef PARITY_ERR_CNT_EN
        .err_clr(err_clr), .err_cnt(err_cnt0),
`endif
        .out_err(out_err0)
    );

    stream_parity_unit #(.WIDTH(8), .FRAME_LEN(4), .ODD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode_check(mode_check),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_last(in_last), .par_in(par_in), .out_valid(out_valid1),
        .out_ready(out_ready), .out_parity(out_parity1),
        .out_words(out_words1),
`ifdef PARITY_ERR_CNT_EN
        .err_clr(err_clr), .err_cnt(err_cnt1),
`endif
        .out_err(out_err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // drive one word at a negedge; it transfers on the next posedge
    task automatic push(input logic [7:0] d, input logic l, input logic p);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        par_in   = p;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_parity", 32'(out_parity0), 32'd0);
        chk("rst_words", 32'(out_words0), 32'd0);
        chk("rst_err", 32'(out_err0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);

        // full-length GEN frame
        mode_check = 1'b0;
        push(8'h48, 1'b0, 1'b0);
        push(8'h69, 1'b0, 1'b0);
        push(8'h31, 1'b0, 1'b0);
        chk("t1_no_valid_early", 32'(out_valid0), 32'd0);
        push(8'h00, 1'b0, 1'b0);
        chk("t1_valid", 32'(out_valid0), 32'd1);
        chk("t1_in_ready", 32'(in_ready0), 32'd0);
        chk("t1_parity", 32'(out_parity0), 32'd1);
        chk("t1_words", 32'(out_words0), 32'd4);
        chk("t1_err", 32'(out_err0), 32'd0);
        chk("t2_odd_parity", 32'(out_parity1), 32'd0);
        chk("t2_odd_words", 32'(out_words1), 32'd4);
        pop();
        chk("t1_valid_drop", 32'(out_valid0), 32'd0);
        chk("t1_ready_back", 32'(in_ready0), 32'd1);

        // CHECK frame ended early with in_last
        mode_check = 1'b1;
        push(8'h01, 1'b0, 1'b0);
        mode_check = 1'b0;
        push(8'h02, 1'b1, 1'b1);
        chk("t3_parity", 32'(out_parity0), 32'd0);
        chk("t3_words", 32'(out_words0), 32'd2);
        chk("t3_err", 32'(out_err0), 32'd1);
        chk("t3_odd_err", 32'(out_err1), 32'd0);
        pop();
        mode_check = 1'b1;
        push(8'h01, 1'b0, 1'b0);
        push(8'h02, 1'b1, 1'b0);
        chk("t3b_err", 32'(out_err0), 32'd0);
        chk("t3b_odd_err", 32'(out_err1), 32'd1);
        pop();

        // backpressure in HOLD
        mode_check = 1'b0;
        push(8'h07, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h03;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t4_in_ready", 32'(in_ready0), 32'd0);
            chk("t4_valid", 32'(out_valid0), 32'd1);
            chk("t4_parity", 32'(out_parity0), 32'd1);
            chk("t4_words", 32'(out_words0), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_released", 32'(out_valid0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        push(8'h00, 1'b1, 1'b0);
        chk("t4_next_parity", 32'(out_parity0), 32'd0);
        chk("t4_next_words", 32'(out_words0), 32'd2);
        pop();

        // reset mid-frame discards the partial frame
        push(8'h01, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", 32'(out_valid0), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        push(8'hFF, 1'b0, 1'b0);
        push(8'h01, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        push(8'h00, 1'b0, 1'b0);
        chk("t5_valid", 32'(out_valid0), 32'd1);
        chk("t5_parity", 32'(out_parity0), 32'd1);
        chk("t5_words", 32'(out_words0), 32'd4);
        pop();

`ifdef PARITY_ERR_CNT_EN
        chk("t6_cnt_zero", 32'(err_cnt0), 32'd0);
        mode_check = 1'b1;
        for (int i = 0; i < 300; i++) begin
            push(8'h01, 1'b1, 1'b0);
            pop();
        end
        chk("t6_cnt_sat", 32'(err_cnt0), 32'd255);
        chk("t6_odd_cnt", 32'(err_cnt1), 32'd0);
        push(8'h01, 1'b1, 1'b0);
        err_clr = 1'b1;
        pop();
        err_clr = 1'b0;
        chk("t6_cnt_clr", 32'(err_cnt0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
